// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the PC sequencer.
package pc_pkg;

    // Fetch control state.
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

    // Fixed instruction size; sequential fetch advances by this amount.
    localparam int unsigned INSTR_BYTES = 4;

    // Default vectors, truncated to XLEN where used.
    localparam logic [63:0] DEFAULT_RESET_VECTOR = 64'h0;
    localparam logic [63:0] DEFAULT_TRAP_VECTOR  = 64'h100;

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return address stack. A push when full overwrites the
// oldest entry; push and pop together replace the top entry.
module pc_ras #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_clear,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic [XLEN-1:0] i_data,
    output logic [XLEN-1:0] o_top,
    output logic            o_empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [XLEN-1:0] r_mem [DEPTH];
    logic [PW-1:0]   r_ptr;
    logic [PW:0]     r_count;
    logic [PW-1:0]   w_top_idx;

    // Top of stack is the slot just below the write pointer.
    always_comb begin
        w_top_idx = r_ptr - PW'(1);
        o_top     = r_mem[w_top_idx];
        o_empty   = (r_count == '0);
    end

    // Pointer/count update; storage itself is never reset.
    always_ff @(posedge clk) begin
        if (!reset || i_clear) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else if (i_push && i_pop && !o_empty) begin
            r_mem[w_top_idx] <= i_data;
        end else if (i_push) begin
            r_mem[r_ptr] <= i_data;
            r_ptr        <= r_ptr + PW'(1);
            if (r_count != (PW + 1)'(DEPTH)) begin
                r_count <= r_count + (PW + 1)'(1);
            end
        end else if (i_pop && !o_empty) begin
            r_ptr   <= w_top_idx;
            r_count <= r_count - (PW + 1)'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC generator with BOOT/RUN/HALT control, trap and
// flush redirect. Define PC_SEQUENCER_RAS_EN to build in the return
// address stack (pc_ras); otherwise is_call/is_ret are ignored.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = 64,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEFAULT_TRAP_VECTOR),
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush_valid,
    input  logic [XLEN-1:0] flush_target,
    input  logic            trap_valid,
    input  logic            halt_req,
    input  logic            resume_req,
    input  logic            is_call,
    input  logic            is_ret,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus4,
    output logic            pc_valid,
    output logic            misalign_err
);

    pc_state_e       r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_pc_valid;
    logic            r_misalign;

    logic            w_flush_take;
    logic            w_halt_go;
    logic            w_resume_go;
    logic            w_advance;
    logic            w_ras_empty;
    logic [XLEN-1:0] w_ras_top;
    logic [XLEN-1:0] w_pc_next;

    assign pc_out       = r_pc;
    assign pc_valid     = r_pc_valid;
    assign misalign_err = r_misalign;
    assign pc_plus4     = r_pc + XLEN'(INSTR_BYTES);

    // Redirect and control decode; halt/resume together cancel out.
    always_comb begin
        w_flush_take = flush_valid && !trap_valid;
        w_halt_go    = halt_req && !resume_req;
        w_resume_go  = resume_req && !halt_req;
        w_advance    = (r_state == RUN) && !trap_valid && !flush_valid && !stall && !w_halt_go;
    end

`ifdef PC_SEQUENCER_RAS_EN
    pc_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .reset   (reset),
        .i_clear (trap_valid),
        .i_push  (w_advance && is_call),
        .i_pop   (w_advance && is_ret),
        .i_data  (pc_plus4),
        .o_top   (w_ras_top),
        .o_empty (w_ras_empty)
    );
`else
    logic w_unused;
    assign w_unused    = ^{is_call, is_ret, RAS_DEPTH[0]};
    assign w_ras_top   = '0;
    assign w_ras_empty = 1'b1;
`endif

    // Next-PC selection: trap > flush > hold (stall/halt/boot) > return > +4.
    always_comb begin
        w_pc_next = r_pc;
        if (trap_valid) begin
            w_pc_next = TRAP_VECTOR;
        end else if (w_flush_take) begin
            w_pc_next = {flush_target[XLEN-1:2], 2'b00};
        end else if (w_advance) begin
            w_pc_next = (is_ret && !w_ras_empty) ? w_ras_top : pc_plus4;
        end
    end

    // State machine with registered pc_valid, PC and misalign pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= BOOT;
            r_pc_valid <= 1'b0;
            r_pc       <= RESET_VECTOR;
            r_misalign <= 1'b0;
        end else begin
            r_pc       <= w_pc_next;
            r_misalign <= w_flush_take && (flush_target[1:0] != 2'b00);
            case (r_state)
                BOOT: begin
                    r_state    <= RUN;
                    r_pc_valid <= 1'b1;
                end
                RUN: begin
                    if (!trap_valid && w_halt_go) begin
                        r_state    <= HALT;
                        r_pc_valid <= 1'b0;
                    end
                end
                HALT: begin
                    if (trap_valid || w_resume_go) begin
                        r_state    <= RUN;
                        r_pc_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= BOOT;
                    r_pc_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench. The driver applies stimulus at the
// falling edge, runs a behavioural model and queues the expected outputs;
// the monitor pops one entry after each rising edge and compares.
module tb_pc_sequencer;

`ifdef PC_SEQUENCER_RAS_EN
    localparam bit RasEn = 1'b1;
`else
    localparam bit RasEn = 1'b0;
`endif
    localparam int unsigned Depth = 4;
    localparam logic [63:0] ResetVec = 64'h0;
    localparam logic [63:0] TrapVec  = 64'h100;

    logic        clk = 1'b0;
    logic        reset, stall, flush_valid, trap_valid;
    logic        halt_req, resume_req, is_call, is_ret;
    logic [63:0] flush_target;
    logic [63:0] pc_out, pc_plus4;
    logic        pc_valid, misalign_err;

    int checks   = 0;
    int failures = 0;

    // Model state: mode 0=boot, 1=run, 2=halt; RAS as a bounded queue.
    logic [63:0] m_pc;
    int          m_mode;
    logic        m_mis;
    logic [63:0] m_ras[$];

    logic [63:0] exp_pc_q[$];
    logic        exp_v_q[$];
    logic        exp_m_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .flush_valid  (flush_valid),
        .flush_target (flush_target),
        .trap_valid   (trap_valid),
        .halt_req     (halt_req),
        .resume_req   (resume_req),
        .is_call      (is_call),
        .is_ret       (is_ret),
        .pc_out       (pc_out),
        .pc_plus4     (pc_plus4),
        .pc_valid     (pc_valid),
        .misalign_err (misalign_err)
    );

    task automatic set_idle();
        reset        = 1'b1;
        stall        = 1'b0;
        flush_valid  = 1'b0;
        flush_target = 64'h0;
        trap_valid   = 1'b0;
        halt_req     = 1'b0;
        resume_req   = 1'b0;
        is_call      = 1'b0;
        is_ret       = 1'b0;
    endtask

    // One clock of the architectural rules applied to the current inputs.
    task automatic model_step();
        logic [63:0] nxt;
        if (!reset) begin
            m_pc   = ResetVec;
            m_mode = 0;
            m_mis  = 1'b0;
            m_ras.delete();
            return;
        end
        m_mis = flush_valid && !trap_valid && (flush_target[1:0] != 2'b00);
        if (trap_valid) begin
            m_pc   = TrapVec;
            m_mode = 1;
            m_ras.delete();
        end else begin
            if (flush_valid) m_pc = flush_target & ~64'h3;
            if (m_mode == 0) begin
                m_mode = 1;
            end else if (m_mode == 2) begin
                if (resume_req && !halt_req) m_mode = 1;
            end else if (halt_req && !resume_req) begin
                m_mode = 2;
            end else if (!flush_valid && !stall) begin
                nxt = m_pc + 64'd4;
                if (RasEn && is_ret && m_ras.size() > 0) nxt = m_ras.pop_back();
                if (RasEn && is_call) begin
                    m_ras.push_back(m_pc + 64'd4);
                    if (m_ras.size() > Depth) void'(m_ras.pop_front());
                end
                m_pc = nxt;
            end
        end
    endtask

    // Apply current inputs for one cycle and queue the expected response.
    task automatic step(input string tag);
        model_step();
        exp_pc_q.push_back(m_pc);
        exp_v_q.push_back(m_mode == 1);
        exp_m_q.push_back(m_mis);
        tag_q.push_back(tag);
        @(negedge clk);
    endtask

    // Monitor: compare every registered output after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_pc_q.size() > 0) begin
                logic [63:0] e_pc;
                logic        e_v, e_m;
                string       t;
                e_pc = exp_pc_q.pop_front();
                e_v  = exp_v_q.pop_front();
                e_m  = exp_m_q.pop_front();
                t    = tag_q.pop_front();
                checks += 4;
                if (pc_out !== e_pc) begin
                    failures++;
                    $display("FAIL %s pc_out got=%h exp=%h @%0t", t, pc_out, e_pc, $time);
                end
                if (pc_plus4 !== e_pc + 64'd4) begin
                    failures++;
                    $display("FAIL %s pc_plus4 got=%h exp=%h", t, pc_plus4, e_pc + 64'd4);
                end
                if (pc_valid !== e_v) begin
                    failures++;
                    $display("FAIL %s pc_valid got=%b exp=%b @%0t", t, pc_valid, e_v, $time);
                end
                if (misalign_err !== e_m) begin
                    failures++;
                    $display("FAIL %s misalign got=%b exp=%b @%0t", t, misalign_err, e_m, $time);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        set_idle();
        @(negedge clk);

        // Reset for two cycles, then boot and sequential fetch.
        reset = 1'b0; step("reset0");
        step("reset1");
        set_idle();
        repeat (3) step("boot_seq");
        while (m_pc != 64'h40) step("walk");

        // Flush overrides stall; misaligned target is truncated.
        stall = 1'b1; flush_valid = 1'b1; flush_target = 64'h203;
        step("flush_misalign");
        set_idle(); stall = 1'b1;
        step("stall_hold");
        stall = 1'b0;
        step("after_stall");

        // Wrap at the top of the address space.
        flush_valid = 1'b1; flush_target = 64'hFFFF_FFFF_FFFF_FFFC;
        step("flush_top");
        set_idle();
        step("wrap");
        step("post_wrap");

        // Five calls into a four-entry stack, then five returns.
        for (int i = 1; i <= 5; i++) begin
            flush_valid = 1'b1; flush_target = 64'(i * 16);
            step("ras_goto");
            set_idle(); is_call = 1'b1;
            step("ras_call");
            set_idle();
        end
        is_ret = 1'b1;
        repeat (5) step("ras_ret");
        is_call = 1'b1;
        step("call_ret");
        set_idle();

        // Halt, ignored inputs in halt, flush and trap in halt.
        is_call = 1'b1; step("pre_halt_call");
        set_idle(); halt_req = 1'b1; step("halt");
        set_idle(); is_ret = 1'b1; is_call = 1'b1; step("halt_idle");
        set_idle(); flush_valid = 1'b1; flush_target = 64'h301; step("halt_flush");
        set_idle(); trap_valid = 1'b1; stall = 1'b1; step("halt_trap");
        set_idle(); is_ret = 1'b1; step("ret_after_trap");

        // Simultaneous halt/resume, resume, halt with trap.
        set_idle(); halt_req = 1'b1; resume_req = 1'b1; step("halt_resume_run");
        set_idle(); halt_req = 1'b1; step("halt2");
        set_idle(); halt_req = 1'b1; resume_req = 1'b1; step("halt_resume_halt");
        set_idle(); resume_req = 1'b1; step("resume");
        set_idle(); halt_req = 1'b1; trap_valid = 1'b1; step("halt_trap_run");

        // Reset wins over trap during stall.
        set_idle(); stall = 1'b1; step("stall");
        reset = 1'b0; trap_valid = 1'b1; step("reset_trap");
        set_idle(); repeat (2) step("reboot");

        // Randomised traffic.
        for (int n = 0; n < 600; n++) begin
            reset       = ($urandom_range(63) != 0);
            stall       = ($urandom_range(3) == 0);
            flush_valid = ($urandom_range(7) == 0);
            trap_valid  = ($urandom_range(15) == 0);
            halt_req    = ($urandom_range(15) == 0);
            resume_req  = ($urandom_range(3) == 0);
            is_call     = ($urandom_range(3) == 0);
            is_ret      = ($urandom_range(3) == 0);
            flush_target = {$urandom(), $urandom()};
            if ($urandom_range(7) == 0) flush_target[63:4] = '1;
            step("random");
        end
        set_idle();
        step("drain");

        checks++;
        if (exp_pc_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending got=%0d exp=0", exp_pc_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter XLEN, default 64, PC width in bits.
REQ-002 Parameter RESET_VECTOR, default 0, PC value after reset.
REQ-003 Parameter TRAP_VECTOR, default 'h100, PC loaded on trap.
REQ-004 Parameter RAS_DEPTH, default 4, return-address-stack entries (power of 2, >=2).
REQ-005 clk  in  1  single system clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-low reset; sampled only at rising clk.
REQ-007 stall  in  1  hazard-unit hold; 1 freezes PC.
REQ-008 flush_valid  in  1  redirect request from execute stage (taken branch, mispredict, jump).
REQ-009 flush_target  in  XLEN  redirect address, valid with flush_valid.
REQ-010 trap_valid  in  1  exception request; loads TRAP_VECTOR.
REQ-011 halt_req  in  1  enter HALT state; resume_req  in  1  leave HALT.
REQ-012 is_call  in  1  predecoded call at current PC; is_ret  in  1  predecoded return at current PC.
REQ-013 pc_out  out  XLEN  current fetch address (registered).
REQ-014 pc_plus4  out  XLEN  pc_out + 4, combinational, modulo 2^XLEN.
REQ-015 pc_valid  out  1  1 when pc_out is a valid fetch address.
REQ-016 misalign_err  out  1  registered one-cycle pulse when a flush_target has bits [1:0] != 0.

Function
REQ-017 States SHALL be BOOT, RUN, HALT; BOOT -> RUN unconditionally after one cycle; RUN -> HALT on halt_req; HALT -> RUN on resume_req.
REQ-018 pc_valid SHALL be 0 in BOOT and HALT, 1 in RUN.
REQ-019 Next-PC priority in RUN SHALL be: trap_valid > flush_valid > stall > RAS pop (is_ret) > pc_plus4.
REQ-020 trap_valid and flush_valid SHALL override stall and SHALL be honoured in HALT (trap also forces RUN).
REQ-021 flush_target SHALL be loaded with bits [1:0] forced to 0; misalign_err SHALL pulse on the following cycle.
REQ-022 Sequential increment at 2^XLEN-4 SHALL wrap to 0 with no error.
REQ-023 With stall=1 and no trap/flush, pc_out, state and RAS SHALL hold exactly.
REQ-024 halt_req and resume_req asserted together SHALL be ignored; halt_req and trap_valid together: trap wins, state RUN.
REQ-025 Update latency SHALL be one cycle: inputs sampled at edge N, pc_out reflects them after edge N.

Reset
REQ-026 While reset=0 at a rising edge: pc_out=RESET_VECTOR, state=BOOT, misalign_err=0, RAS empty, pc_valid=0.
REQ-027 Reset SHALL take priority over every other input, including mid-stall, mid-halt and simultaneous trap.

Configuration
REQ-028 Macro PC_SEQUENCER_RAS_EN compiles in the return address stack.
REQ-029 With PC_SEQUENCER_RAS_EN: on an advancing cycle is_call pushes pc_plus4; is_ret pops top into pc_out; call+ret together replaces top with pc_plus4 after using old top.
REQ-030 Push when full SHALL overwrite the oldest entry (circular); pop when empty SHALL fall back to pc_plus4.
REQ-031 trap_valid SHALL clear the RAS; flush_valid SHALL not modify it.
REQ-032 Without the macro: no RAS storage, is_call/is_ret ports remain but are ignored, is_ret yields pc_plus4.

Structure
REQ-033 Package pc_pkg SHALL hold the state enum (BOOT/RUN/HALT), INSTR_BYTES=4 and default vector constants.
REQ-034 The RAS SHALL be a sub-module pc_ras (push, pop, top, empty, clear), instantiated only under the macro.

Verification
REQ-035 Reset low 2 cycles, release, stall=0 -> pc_out 0,0,4,8; pc_valid 0 in BOOT, 1 from first RUN cycle.
REQ-036 At pc_out=0x40, stall=1 and flush_valid=1 target 0x203 -> pc_out=0x200 next cycle, misalign_err=1 one cycle.
REQ-037 XLEN=64, pc_out=0xFFFF_FFFF_FFFF_FFFC, no events -> pc_out=0 next cycle.
REQ-038 RAS_EN, RAS_DEPTH=4: calls at 0x10,0x20,0x30,0x40,0x50 then 5 rets -> targets 0x54,0x44,0x34,0x24, then pc_plus4.
REQ-039 halt_req in RUN -> pc_valid=0, pc_out held; trap_valid in HALT -> pc_out=0x100, RUN, RAS empty.
REQ-040 reset=0 asserted with trap_valid=1 during stall -> pc_out=RESET_VECTOR, state BOOT.
